// File: rtl/soc_system_pio_edge_irq_if.sv
// Avalon-MM slave bundle for the edge-capturing input PIO.
// Clock and reset stay outside as plain ports.
interface soc_system_pio_edge_irq_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/soc_system_pio_edge_irq.sv
// Input PIO with per-bit rise/fall capture, W1C clear, irq mask and arm delay.
// Optional debounce filter is built when SOC_PIO_DEBOUNCE_EN is defined.
module soc_system_pio_edge_irq #(
    parameter int WIDTH           = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic                   clk,
    input  logic                   reset,
    soc_system_pio_edge_irq_if.slave bus,
    input  logic [WIDTH-1:0]       in_port,
    output logic                   irq
);

    localparam logic [2:0] ARM_LAST = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] s;
    logic             dbn;

    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [2:0]       arm_cnt_q;
    logic             armed_q;
    logic             irq_q;
    logic [31:0]      rd_q, rd_d;

    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] set;
    logic             unused_cfg;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign raw = sync_q[SYNC_STAGES-1];

`ifdef SOC_PIO_DEBOUNCE_EN
    localparam int DBW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] filt_q;
    logic [DBW-1:0]   dbc_q [WIDTH];

    // A bit must disagree with the filtered value for DEBOUNCE_CYCLES edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_q <= '0;
            for (int i = 0; i < WIDTH; i++) dbc_q[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (raw[i] == filt_q[i]) begin
                    dbc_q[i] <= '0;
                end else if (dbc_q[i] == DB_LAST) begin
                    filt_q[i] <= raw[i];
                    dbc_q[i]  <= '0;
                end else begin
                    dbc_q[i] <= dbc_q[i] + 1'b1;
                end
            end
        end
    end

    assign s   = filt_q;
    assign dbn = 1'b1;
`else
    assign s   = raw;
    assign dbn = 1'b0;
`endif

    assign wr   = bus.chipselect & ~bus.write_n;
    assign wd   = bus.writedata[WIDTH-1:0];
    assign rise = armed_q ? (s & ~prev_q) : '0;
    assign fall = armed_q ? (~s & prev_q) : '0;
    assign set  = (rise & rise_en_q) | (fall & fall_en_q);
    assign w1c  = (wr && bus.address == 3'd3) ? wd : '0;

    assign unused_cfg = ^{bus.writedata, DEBOUNCE_CYCLES};

    always_comb begin
        mask_d    = mask_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        // A new edge wins over a clear landing in the same cycle.
        cap_d     = set | (cap_q & ~w1c);
        if (wr) begin
            case (bus.address)
                3'd1:    mask_d    = wd;
                3'd2:    rise_en_d = wd;
                3'd4:    fall_en_d = wd;
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_d = '0;
        case (bus.address)
            3'd0:    rd_d = 32'(s);
            3'd1:    rd_d = 32'(mask_q);
            3'd2:    rd_d = 32'(rise_en_q);
            3'd3:    rd_d = 32'(cap_q);
            3'd4:    rd_d = 32'(fall_en_q);
            3'd5:    rd_d = {16'h0, 8'(SYNC_STAGES), 6'h0, dbn, armed_q};
            default: rd_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q    <= '0;
            mask_q    <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            cap_q     <= '0;
            arm_cnt_q <= '0;
            armed_q   <= 1'b0;
            irq_q     <= 1'b0;
            rd_q      <= '0;
        end else begin
            prev_q    <= s;
            mask_q    <= mask_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            cap_q     <= cap_d;
            irq_q     <= |(cap_q & mask_q);
            rd_q      <= rd_d;
            if (!armed_q) begin
                if (arm_cnt_q == ARM_LAST) armed_q <= 1'b1;
                else arm_cnt_q <= arm_cnt_q + 1'b1;
            end
        end
    end

    assign irq          = irq_q;
    assign bus.readdata = rd_q;

endmodule

// File: tb/tb_soc_system_pio_edge_irq.sv
// Directed bench for soc_system_pio_edge_irq (WIDTH=16, SYNC_STAGES=2).
// Debounce vectors run instead of the main set when SOC_PIO_DEBOUNCE_EN is defined.
module tb_soc_system_pio_edge_irq;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_port;
    logic        irq;
    logic [31:0] d;
    int          n_chk  = 0;
    int          n_fail = 0;

    soc_system_pio_edge_irq_if bus ();

    soc_system_pio_edge_irq #(
        .WIDTH(16),
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave),
        .in_port(in_port),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] v);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = v;
        tick(1);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        bus.address = a;
        tick(1);
        v = bus.readdata;
    endtask

    initial begin
        bus.address    = 3'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        reset          = 1'b1;
`ifdef SOC_PIO_DEBOUNCE_EN
        in_port = 16'h0000;
        tick(3);
        check("rst_rd", bus.readdata, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        reset = 1'b0;
        tick(6);
        rd(3'd5, d);
        check("db_status", d, 32'h0000_0203);
        wr(3'd2, 32'h1);
        wr(3'd1, 32'h1);
        in_port = 16'h0001;
        tick(5);
        in_port = 16'h0000;
        tick(20);
        rd(3'd3, d);
        check("db_short_cap", d, 32'h0);
        check("db_short_irq", {31'h0, irq}, 32'h0);
        in_port = 16'h0001;
        tick(11);
        check("db_long_irq_early", {31'h0, irq}, 32'h0);
        tick(1);
        check("db_long_irq", {31'h0, irq}, 32'h1);
        in_port = 16'h0000;
        rd(3'd3, d);
        check("db_long_cap", d, 32'h1);
`else
        in_port = 16'hFFFF;
        tick(3);
        check("rst_rd", bus.readdata, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        reset = 1'b0;
        rd(3'd5, d);
        check("status_unarmed", d, 32'h0000_0200);
        wr(3'd2, 32'hFFFF_FFFF);
        wr(3'd4, 32'h0000_FFFF);
        wr(3'd1, 32'h0000_FFFF);
        tick(3);
        rd(3'd3, d);
        check("pwrup_cap", d, 32'h0);
        check("pwrup_irq", {31'h0, irq}, 32'h0);
        rd(3'd0, d);
        check("pwrup_data", d, 32'h0000_FFFF);
        rd(3'd5, d);
        check("status_armed", d, 32'h0000_0201);
        rd(3'd2, d);
        check("rise_en_upper", d, 32'h0000_FFFF);

        wr(3'd2, 32'h0);
        wr(3'd4, 32'h0);
        wr(3'd1, 32'h0);
        in_port = 16'h0000;
        tick(5);
        in_port = 16'h0100;
        tick(5);
        rd(3'd3, d);
        check("disabled_cap", d, 32'h0);
        wr(3'd2, 32'h0001);
        wr(3'd1, 32'h0001);
        wr(3'd4, 32'h0100);

        in_port = 16'h0101;
        tick(3);
        check("rise_irq_early", {31'h0, irq}, 32'h0);
        tick(1);
        check("rise_irq", {31'h0, irq}, 32'h1);
        rd(3'd3, d);
        check("rise_cap", d, 32'h0001);
        in_port = 16'h0100;
        tick(5);
        rd(3'd3, d);
        check("fall0_ignored", d, 32'h0001);

        wr(3'd3, 32'h1);
        check("w1c_irq_hold", {31'h0, irq}, 32'h1);
        tick(1);
        check("w1c_irq_drop", {31'h0, irq}, 32'h0);
        rd(3'd3, d);
        check("w1c_cap", d, 32'h0);

        in_port = 16'h0000;
        tick(3);
        rd(3'd3, d);
        check("fall8_cap", d, 32'h0100);
        check("fall8_masked_irq", {31'h0, irq}, 32'h0);
        wr(3'd1, 32'h0101);
        check("mask_irq_early", {31'h0, irq}, 32'h0);
        tick(1);
        check("mask_irq", {31'h0, irq}, 32'h1);

        in_port = 16'h0001;
        tick(3);
        rd(3'd3, d);
        check("cap_both", d, 32'h0101);
        wr(3'd3, 32'h1);
        rd(3'd3, d);
        check("w1c_bit0", d, 32'h0100);
        check("w1c_bit0_irq", {31'h0, irq}, 32'h1);
        wr(3'd3, 32'h0);
        rd(3'd3, d);
        check("w0_noop", d, 32'h0100);

        in_port = 16'h0000;
        tick(4);
        in_port = 16'h0001;
        tick(2);
        wr(3'd3, 32'h1);
        rd(3'd3, d);
        check("set_beats_w1c", d, 32'h0101);
        wr(3'd3, 32'h1);
        rd(3'd3, d);
        check("w1c_after_race", d, 32'h0100);

        rd(3'd6, d);
        check("unmapped6", d, 32'h0);
        rd(3'd7, d);
        check("unmapped7", d, 32'h0);
        rd(3'd0, d);
        check("data_live", d, 32'h0000_0001);

        reset = 1'b1;
        tick(1);
        check("midrst_rd", bus.readdata, 32'h0);
        check("midrst_irq", {31'h0, irq}, 32'h0);
        reset = 1'b0;
        rd(3'd1, d);
        check("midrst_mask", d, 32'h0);
        rd(3'd3, d);
        check("midrst_cap", d, 32'h0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
